// File: rtl/argmax_layer_pkg.sv
// Shared fixed-point types and helpers for the network layers, plus the
// state encoding used by the argmax classification stage.
package argmax_layer_pkg;

    localparam int INTEGRAL_WIDTH = 8;
    localparam int FRACTION_WIDTH = 8;
    localparam int FIXED_WIDTH    = INTEGRAL_WIDTH + FRACTION_WIDTH;

    // Signed two's complement value over {integral, fraction}
    typedef struct packed {
        logic [INTEGRAL_WIDTH-1:0] integral;
        logic [FRACTION_WIDTH-1:0] fraction;
    } fixed_point;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } argmax_state_t;

    // Full-width signed compare, a > b; shared with later pooling layers
    function automatic logic fixed_point_greater(input fixed_point a, input fixed_point b);
        logic signed [FIXED_WIDTH-1:0] sa;
        logic signed [FIXED_WIDTH-1:0] sb;
        sa = a;
        sb = b;
        return sa > sb;
    endfunction

endpackage

// File: rtl/argmax_layer.sv
// Classification stage: captures a fixed_point vector when upstream signals
// ready, scans it one element per clock and reports index/value of the
// largest element. Ties keep the lowest index.
module argmax_layer
    import argmax_layer_pkg::*;
#(
    parameter int NUM_INPUTS = 16,
    localparam int INDEX_WIDTH = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   inputs_ready,
    input  fixed_point             inputs [NUM_INPUTS],
    output logic                   busy,
    output logic                   outputs_ready,
    output logic [INDEX_WIDTH-1:0] index,
    output fixed_point             maximum
);

    localparam logic [INDEX_WIDTH-1:0] LAST_COUNT = INDEX_WIDTH'(NUM_INPUTS - 1);
    localparam logic [INDEX_WIDTH-1:0] FIRST_COUNT = INDEX_WIDTH'(1);
    localparam bit SINGLE = (NUM_INPUTS == 1);

    argmax_state_t              state;
    logic [INDEX_WIDTH-1:0]     count;
    fixed_point                 captured [NUM_INPUTS];
    fixed_point                 current;

    // Select the captured element the counter points at; written as a
    // compare-per-entry mux so the single-element build needs no index bits
    always_comb begin
        current = captured[0];
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (count == INDEX_WIDTH'(i)) begin
                current = captured[i];
            end
        end
    end

    // Control FSM with registered outputs; the captured array has no reset
    // because its contents only matter after an accepting edge
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            count         <= '0;
            index         <= '0;
            maximum       <= '0;
            busy          <= 1'b0;
            outputs_ready <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (inputs_ready) begin
                        captured      <= inputs;
                        maximum       <= inputs[0];
                        index         <= '0;
                        count         <= FIRST_COUNT;
                        if (SINGLE) begin
                            state         <= ST_DONE;
                            busy          <= 1'b0;
                            outputs_ready <= 1'b1;
                        end else begin
                            state         <= ST_SCAN;
                            busy          <= 1'b1;
                            outputs_ready <= 1'b0;
                        end
                    end
                end
                ST_SCAN: begin
                    if (fixed_point_greater(current, maximum)) begin
                        maximum <= current;
                        index   <= count;
                    end
                    if (count == LAST_COUNT) begin
                        state         <= ST_DONE;
                        busy          <= 1'b0;
                        outputs_ready <= 1'b1;
                    end else begin
                        count <= count + FIRST_COUNT;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    busy          <= 1'b0;
                    outputs_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
